// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_ctrl
//  Purpose  : Transmit-side UART controller. Serialises one byte per accepted
//             request as an 8N1 frame, LSB first, idle-high line. A baud-rate
//             timer and a bit counter pace the frame. Host handshake is
//             level-sensitive: send must return low before the next byte is
//             accepted.
//  Optional : define UART_TX_PARITY_EN to insert an even-parity bit between
//             the data bits and the stop bit (11-bit frame).
//  Ports    : clk      - system clock, rising-edge
//             reset    - synchronous, active-high reset (aborts any frame)
//             send     - transmit request, level-sensitive
//             din[7:0] - byte to transmit, sampled only on acceptance
//             tx_out   - registered serial line, idle high
//             busy     - high while a frame is on the line
//             tx_done  - one-cycle pulse in the last cycle of the stop bit
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int BAUD_WID     = $clog2(CLKS_PER_BIT)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       send,
   input  logic [7:0] din,
   output logic       tx_out,
   output logic       busy,
   output logic       tx_done
);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      BITS  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4,
      ACK   = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      BITS  = 3'd2,
      STOP  = 3'd4,
      ACK   = 3'd5
   } state_t;
`endif

   localparam logic [BAUD_WID-1:0] c_TICK_MAX = BAUD_WID'(CLKS_PER_BIT - 1);

   state_t              state_q,   state_d;
   logic [BAUD_WID-1:0] timer_q,   timer_d;
   logic [2:0]          bit_cnt_q, bit_cnt_d;
   logic [7:0]          shift_q,   shift_d;
   logic                tx_out_q,  tx_out_d;
   logic                busy_q,    busy_d;
   logic                tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
   logic                parity_q,  parity_d;
`endif

   logic active;
   logic bit_tick;
   logic last_bit;

   // Timer runs only while a frame is on the line; IDLE and ACK hold it at 0.
   assign active   = (state_q != IDLE) && (state_q != ACK);
   assign bit_tick = active && (timer_q == c_TICK_MAX);
   assign last_bit = (state_q == BITS) && bit_tick && (bit_cnt_q == 3'd7);

   always_comb begin
      state_d   = state_q;
      timer_d   = '0;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif

      if (active && !bit_tick) begin
         timer_d = timer_q + BAUD_WID'(1);
      end

      case (state_q)
         IDLE: begin
            if (send) begin
               shift_d = din;
`ifdef UART_TX_PARITY_EN
               // Parity is captured up front because the shifter is consumed.
               parity_d = ^din;
`endif
               state_d = START;
            end
         end
         START: begin
            if (bit_tick) state_d = BITS;
         end
         BITS: begin
            if (bit_tick) begin
               shift_d   = {1'b0, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PAR;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PAR: begin
            if (bit_tick) state_d = STOP;
         end
`endif
         STOP: begin
            if (bit_tick) state_d = ACK;
         end
         ACK: begin
            // Re-arm: a held request never starts a second frame.
            if (!send) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so the registered copies
      // line up cycle-for-cycle with the state they describe.
      tx_out_d = 1'b1;
      case (state_d)
         START:   tx_out_d = 1'b0;
         BITS:    tx_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PAR:     tx_out_d = parity_d;
`endif
         default: tx_out_d = 1'b1;
      endcase
      busy_d    = (state_d != IDLE) && (state_d != ACK);
      // Look-ahead so the pulse occupies the final stop-bit cycle.
      tx_done_d = (state_d == STOP) && (timer_d == c_TICK_MAX);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         bit_cnt_q <= 3'd0;
         shift_q   <= 8'd0;
         tx_out_q  <= 1'b1;
         busy_q    <= 1'b0;
         tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         tx_out_q  <= tx_out_d;
         busy_q    <= busy_d;
         tx_done_q <= tx_done_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign tx_out  = tx_out_q;
   assign busy    = busy_q;
   assign tx_done = tx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_ctrl
//  Purpose  : Self-checking bench for uart_tx_ctrl. Expected line waveforms
//             are built per frame from the byte value (start, data LSB first,
//             optional even parity, stop), each bit held CPB cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic       clk = 1'b0;
   logic       reset;
   logic       send;
   logic [7:0] din;
   logic       tx_out;
   logic       busy;
   logic       tx_done;

   int checks   = 0;
   int failures = 0;

   uart_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
      .clk     (clk),
      .reset   (reset),
      .send    (send),
      .din     (din),
      .tx_out  (tx_out),
      .busy    (busy),
      .tx_done (tx_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".tx_out"},  tx_out,  1'b1);
      check({tag, ".busy"},    busy,    1'b0);
      check({tag, ".tx_done"}, tx_done, 1'b0);
   endtask

   // mode 0: send dropped right after acceptance; mode 1: send held 200 cycles.
   // abort_cyc >= 0 pulses reset in that frame cycle; din_cyc >= 0 changes din.
   task automatic run_frame(input logic [7:0] b, input int mode, input int abort_cyc,
                            input logic [7:0] din_late, input int din_cyc);
      logic exp_bits [NBITS];
      exp_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
      exp_bits[9] = ^b;
`endif
      exp_bits[NBITS-1] = 1'b1;

      din  = b;
      send = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < FRAME; c++) begin
         check($sformatf("frame%02h.c%0d.tx_out", b, c), tx_out, exp_bits[c / CPB]);
         check($sformatf("frame%02h.c%0d.busy", b, c), busy, 1'b1);
         check($sformatf("frame%02h.c%0d.tx_done", b, c), tx_done, c == FRAME - 1);
         if (mode == 0 && c == 0) send = 1'b0;
         if (c == din_cyc) din = din_late;
         if (c == abort_cyc) begin
            reset = 1'b1;
            send  = 1'b0;
            @(posedge clk); #1;
            reset = 1'b0;
            check_idle($sformatf("abort%02h.after", b));
            for (int k = 0; k < 3 * CPB; k++) begin
               @(posedge clk); #1;
               check_idle($sformatf("abort%02h.k%0d", b, k));
            end
            return;
         end
         @(posedge clk); #1;
      end
      if (mode == 1) begin
         for (int k = 0; k < 200 - FRAME; k++) begin
            check_idle($sformatf("hold%02h.k%0d", b, k));
            @(posedge clk); #1;
         end
      end
      check_idle($sformatf("ack%02h", b));
      send = 1'b0;
      @(posedge clk); #1;
      check_idle($sformatf("rearm%02h", b));
   endtask

   initial begin
      reset = 1'b1;
      send  = 1'b0;
      din   = 8'h00;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_idle("reset");

      // A request during reset must not be accepted.
      send = 1'b1;
      din  = 8'h5A;
      @(posedge clk); #1;
      check_idle("send_in_reset");
      reset = 1'b0;
      send  = 1'b0;
      @(posedge clk); #1;
      check_idle("post_reset");

      run_frame(8'hA5, 0, -1, 8'h00, -1);
      run_frame(8'h00, 1, -1, 8'h00, -1);
      run_frame(8'hFF, 0, 4 * CPB + 1, 8'h00, -1);
      run_frame(8'hFF, 0, -1, 8'h00, -1);
      run_frame(8'h3C, 0, -1, 8'hC3, 2 * CPB);
      run_frame(8'h07, 0, -1, 8'h00, -1);
      run_frame(8'h03, 0, -1, 8'h00, -1);

      for (int r = 0; r < 8; r++) begin
         logic [7:0] rb, rl;
         rb = 8'($urandom);
         rl = 8'($urandom);
         run_frame(rb, int'($urandom_range(0, 1)), -1, rl,
                   int'($urandom_range(0, FRAME - 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
